// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, instruction memory with a program-load
// port, and a registered IF/ID output with redirect, stall and sticky fault.
module fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 16,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [31:0]     NOP      = 32'h0000_0013
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [XLEN-1:0]          redirect_pc,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [31:0]              prog_data,
   output logic [XLEN-1:0]          pc,
   output logic [XLEN-1:0]          if_pc,
   output logic [31:0]              if_instr,
   output logic                     if_valid,
   output logic                     fault
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {RUN, HALT} state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_if_pc;
   logic [31:0]     r_instr;
   logic            r_valid;
   logic            r_fault;
   logic [31:0]     r_mem [DEPTH];

   logic [AW-1:0]   w_idx;
   logic            w_pc_ok;
   logic            w_tgt_ok;

   // An address is fetchable only if word-aligned and every bit above the
   // memory index is clear; checked before increment so wrap cannot pass.
   assign w_idx    = r_pc[AW+1:2];
   assign w_pc_ok  = ((r_pc >> (AW + 2)) == '0) && (r_pc[1:0] == 2'b00);
   assign w_tgt_ok = ((redirect_pc >> (AW + 2)) == '0) && (redirect_pc[1:0] == 2'b00);

   // Memory has no reset so program loading works while the core is held in reset.
   always_ff @(posedge clock) begin
      if (prog_we) r_mem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= RUN;
         r_pc    <= RESET_PC;
         r_if_pc <= '0;
         r_instr <= NOP;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (redirect) begin
                  r_instr <= NOP;
                  r_valid <= 1'b0;
                  if (w_tgt_ok) begin
                     r_pc <= redirect_pc;
                  end else begin
                     r_fault <= 1'b1;
                     r_state <= HALT;
                  end
               end else if (!stall) begin
                  if (w_pc_ok) begin
                     r_instr <= r_mem[w_idx];
                     r_if_pc <= r_pc;
                     r_valid <= 1'b1;
                     r_pc    <= r_pc + XLEN'(4);
                  end else begin
                     r_instr <= NOP;
                     r_valid <= 1'b0;
                     r_fault <= 1'b1;
                     r_state <= HALT;
                  end
               end
            end
            HALT: begin
               r_instr <= NOP;
               r_valid <= 1'b0;
               r_fault <= 1'b1;
            end
            default: r_state <= HALT;
         endcase
      end
   end

   assign pc       = r_pc;
   assign if_pc    = r_if_pc;
   assign if_instr = r_instr;
   assign if_valid = r_valid;
   assign fault    = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// all checked against a word-level behavioural model of the fetch stage.
module tb_fetch_unit;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] NOPW  = 32'h0000_0013;

   logic            clock = 1'b0;
   logic            reset;
   logic            stall;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            prog_we;
   logic [3:0]      prog_addr;
   logic [31:0]     prog_data;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;
   logic            if_valid;
   logic            fault;

   fetch_unit #(
      .XLEN    (XLEN),
      .DEPTH   (DEPTH),
      .RESET_PC(32'h0),
      .NOP     (NOPW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .pc         (pc),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .if_valid   (if_valid),
      .fault      (fault)
   );

   always #5 clock = ~clock;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // Reference model state
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_pc, m_if_pc, m_instr;
   logic        m_valid, m_fault, m_halt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"},    pc,              m_pc);
      chk({tag, ".if_pc"}, if_pc,           m_if_pc);
      chk({tag, ".instr"}, if_instr,        m_instr);
      chk({tag, ".valid"}, {31'b0, if_valid}, {31'b0, m_valid});
      chk({tag, ".fault"}, {31'b0, fault},  {31'b0, m_fault});
   endtask

   task automatic model_reset();
      m_pc = 0; m_if_pc = 0; m_instr = NOPW; m_valid = 0; m_fault = 0; m_halt = 0;
   endtask

   // One rising edge: fetch sees the memory contents from before this edge's write.
   task automatic model_edge();
      logic [31:0] old_word;
      if (!reset) begin
         model_reset();
      end else if (!m_halt) begin
         if (redirect) begin
            m_instr = NOPW;
            m_valid = 0;
            if (redirect_pc % 4 == 0 && redirect_pc < DEPTH * 4) m_pc = redirect_pc;
            else begin m_fault = 1; m_halt = 1; end
         end else if (!stall) begin
            if (m_pc < DEPTH * 4) begin
               old_word = m_mem[m_pc / 4];
               m_instr  = old_word;
               m_if_pc  = m_pc;
               m_valid  = 1;
               m_pc     = m_pc + 4;
            end else begin
               m_instr = NOPW; m_valid = 0; m_fault = 1; m_halt = 1;
            end
         end
      end
      if (prog_we) m_mem[prog_addr] = prog_data;
   endtask

   task automatic cycle(input string tag, input logic st, input logic rd, input logic [31:0] rpc,
                        input logic we, input logic [3:0] wa, input logic [31:0] wd);
      stall = st; redirect = rd; redirect_pc = rpc;
      prog_we = we; prog_addr = wa; prog_data = wd;
      @(posedge clock);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic seq(input string tag);
      cycle(tag, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
   endtask

   // Asserts reset between edges and checks outputs before the next edge arrives.
   task automatic pulse_reset(input string tag);
      stall = 0; redirect = 0; prog_we = 0;
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      reset = 1'b1;
   endtask

   logic [31:0] prog [4] = '{32'h002081B3, 32'h40208233, 32'h0020F2B3, 32'h00A08313};

   initial begin
      reset = 1'b0; stall = 0; redirect = 0; redirect_pc = 0;
      prog_we = 0; prog_addr = 0; prog_data = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hx;
      model_reset();

      // Program load while reset is held low
      for (int i = 0; i < DEPTH; i++)
         cycle("load", 1'b0, 1'b0, 32'h0, 1'b1, 4'(i), (i < 4) ? prog[i] : 32'h1000_0000 + 32'(i));
      chk("reset.pc", pc, 32'h0);
      chk("reset.instr", if_instr, NOPW);
      reset = 1'b1;

      seq("f0");
      chk("f0.instr", if_instr, 32'h002081B3);
      seq("f1");
      chk("f1.pc", pc, 32'h8);
      cycle("stall0", 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      cycle("stall1", 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      chk("stall.instr", if_instr, 32'h40208233);
      chk("stall.pc", pc, 32'h8);
      seq("f2");
      chk("f2.if_pc", if_pc, 32'h8);
      seq("f3");
      chk("f3.instr", if_instr, 32'h00A08313);

      cycle("redir_stall", 1'b1, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
      chk("redir.pc", pc, 32'h0);
      chk("redir.instr", if_instr, NOPW);
      seq("after_redir");
      chk("after_redir.instr", if_instr, 32'h002081B3);

      // pc=4 is fetched on the same edge word 1 is overwritten
      cycle("rbw", 1'b0, 1'b0, 32'h0, 1'b1, 4'h1, 32'hDEADBEEF);
      chk("rbw.instr", if_instr, 32'h40208233);
      cycle("redir4", 1'b0, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0);
      seq("refetch");
      chk("refetch.instr", if_instr, 32'hDEADBEEF);

      for (int i = 0; i < 40 && !m_halt; i++) begin
         seq("run");
         if (m_if_pc == 32'h3C && m_valid) chk("last.pc", pc, 32'h40);
      end
      chk("end_fault", {31'b0, fault}, 32'd1);

      cycle("halt_redir", 1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
      chk("halt.pc", pc, 32'h40);
      pulse_reset("midrst");
      chk("midrst.fault", {31'b0, fault}, 32'd0);
      seq("post_rst");
      chk("post_rst.instr", if_instr, 32'h002081B3);

      cycle("misalign", 1'b0, 1'b1, 32'h6, 1'b0, 4'h0, 32'h0);
      chk("misalign.fault", {31'b0, fault}, 32'd1);
      cycle("ignored", 1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
      pulse_reset("rst2");
      cycle("oor", 1'b0, 1'b1, 32'h8000_0010, 1'b0, 4'h0, 32'h0);
      pulse_reset("rst3");

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         logic        st, rd, we;
         logic [31:0] tgt;
         if (m_halt && $urandom_range(0, 3) == 0) begin
            pulse_reset("rnd_rst");
         end else begin
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 9) == 0);
            we = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 7))
               0:       tgt = 32'($urandom_range(0, 63));
               1:       tgt = $urandom;
               default: tgt = 32'($urandom_range(0, DEPTH - 1)) * 4;
            endcase
            cycle("rnd", st, rd, tgt, we, 4'($urandom_range(0, DEPTH - 1)), $urandom);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
